// File: rtl/tape_arbiter.sv
// tape_arbiter: shares the single-port byte-wide tape RAM between the CPU core
// and the host/debug port. The core has fixed priority. An anti-starvation
// counter lets a waiting host win after STARVE_LIMIT denied cycles. The host
// can lock the tape for atomic inspect/patch sequences. One access is accepted
// per cycle, with a registered RAM drive and a registered read return.
module tape_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    input  logic                  host_lock,
    output logic                  locked,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic                  locked_q;
    logic [3:0]            starve_q, starve_d;

    logic                  core_gnt_s, host_gnt_s;
    logic                  core_acc_s, host_acc_s;
    logic                  starve_hit_s;

    // stage 1: RAM drive plus owner/read tag
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  owner_q, owner_d;      // 1 = host, 0 = core

    // stage 2: read in flight, RAM data arrives this cycle
    logic                  rd_pend_q;
    logic                  rd_owner_q;

    // stage 3: return registers
    logic                  core_rvalid_q, host_rvalid_q;
    logic [DATA_WIDTH-1:0] core_rdata_q, host_rdata_q;

    assign starve_hit_s = (starve_q == STARVE_MAX);
    assign core_acc_s   = core_req & core_gnt_s;
    assign host_acc_s   = host_req & host_gnt_s;

    // Grant decode: core has priority unless the host has waited long enough; locked mode is host-only
    always_comb begin
        core_gnt_s = 1'b0;
        host_gnt_s = 1'b0;
        case (state_q)
            ST_ARB: begin
                core_gnt_s = core_req & ~(host_req & starve_hit_s);
                host_gnt_s = host_req & ~core_gnt_s;
            end
            ST_LOCKED: begin
                core_gnt_s = 1'b0;
                host_gnt_s = host_req;
            end
            default: begin
                core_gnt_s = 1'b0;
                host_gnt_s = 1'b0;
            end
        endcase
    end

    // Next lock state and saturating starve counter
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            ST_ARB: begin
                if (host_acc_s && host_lock) begin
                    state_d = ST_LOCKED;
                end else begin
                    state_d = ST_ARB;
                end
                if (host_req && !host_gnt_s) begin
                    starve_d = starve_hit_s ? starve_q : (starve_q + 4'd1);
                end else begin
                    starve_d = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (host_acc_s && !host_lock) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_LOCKED;
                end
                starve_d = 4'd0;
            end
            default: begin
                state_d  = ST_ARB;
                starve_d = 4'd0;
            end
        endcase
    end

    // Winner mux feeding the registered RAM drive; idle cycles drive zeros
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        owner_d     = 1'b0;
        if (host_acc_s) begin
            mem_en_d    = 1'b1;
            mem_we_d    = host_we;
            mem_addr_d  = host_addr;
            mem_wdata_d = host_wdata;
            owner_d     = 1'b1;
        end else if (core_acc_s) begin
            mem_en_d    = 1'b1;
            mem_we_d    = core_we;
            mem_addr_d  = core_addr;
            mem_wdata_d = core_wdata;
            owner_d     = 1'b0;
        end else begin
            mem_en_d    = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            owner_d     = 1'b0;
        end
    end

    // Lock FSM with registered locked flag and starve counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_ARB;
            locked_q <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            locked_q <= (state_d == ST_LOCKED);
            starve_q <= starve_d;
        end
    end

    // Access pipeline: RAM drive, read-in-flight tag, per-owner return capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            owner_q       <= 1'b0;
            rd_pend_q     <= 1'b0;
            rd_owner_q    <= 1'b0;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            host_rdata_q  <= '0;
        end else begin
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            owner_q       <= owner_d;
            rd_pend_q     <= mem_en_q & ~mem_we_q;
            rd_owner_q    <= owner_q;
            core_rvalid_q <= rd_pend_q & ~rd_owner_q;
            host_rvalid_q <= rd_pend_q & rd_owner_q;
            if (rd_pend_q && !rd_owner_q) begin
                core_rdata_q <= mem_rdata;
            end
            if (rd_pend_q && rd_owner_q) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    assign core_gnt    = core_gnt_s;
    assign host_gnt    = host_gnt_s;
    assign locked      = locked_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign core_rvalid = core_rvalid_q;
    assign core_rdata  = core_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;

endmodule

// File: doc/tape_arbiter.md
Name: tape_arbiter

Overview:
- Shares the single-port, byte-wide tape RAM between two requesters: the CPU core and a host/debug port (tape preload, inspection, dump).
- Fixed core priority, with an anti-starvation counter for the host.
- The host can lock the tape, stalling the core so it can inspect or patch the tape atomically.
- Pipelined: accepts one access per cycle, with registered RAM drive and registered read return.

Parameters:
- ADDR_WIDTH, 16, tape address width (matches core sp width).
- DATA_WIDTH, 8, tape cell width.
- STARVE_LIMIT, 4, consecutive cycles host_req may be denied before the host wins arbitration (legal range 1..15).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request; held until granted.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_WIDTH  tape address.
- core_wdata  in  DATA_WIDTH  write data.
- core_gnt  out  1  combinational grant; access is accepted on a cycle where req&gnt.
- core_rvalid  out  1  one-cycle pulse: read data returned.
- core_rdata  out  DATA_WIDTH  read data, valid with core_rvalid.
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same as the core_* set, for the host.
- host_lock  in  1  sampled with an accepted host access; 1 = enter/stay in locked mode.
- locked  out  1  registered; 1 while the host owns the tape exclusively.
- mem_en  out  1  registered RAM enable.
- mem_we  out  1  registered RAM write enable.
- mem_addr  out  ADDR_WIDTH  registered RAM address.
- mem_wdata  out  DATA_WIDTH  registered RAM write data.
- mem_rdata  in  DATA_WIDTH  synchronous RAM read data, valid the cycle after mem_en&!mem_we.

Behaviour:
Reset:
- reset_n low immediately clears all registered outputs and state: mem_*, *_rvalid, *_rdata = 0; locked = 0; starve counter = 0; state = ARB.
- Any in-flight read is dropped; no rvalid is produced for it after reset releases.

States:
- ARB: core_gnt = core_req & !(host_req & starve==STARVE_LIMIT); host_gnt = host_req & !core_gnt.
- LOCKED: core_gnt = 0; host_gnt = host_req.

Transitions:
- ARB -> LOCKED on an accepted host access with host_lock=1.
- LOCKED -> ARB on an accepted host access with host_lock=0. That access itself completes normally. Core may be granted from the next cycle.

Starve counter (4 bits):
- Increments each cycle host_req=1 and host_gnt=0, saturating at STARVE_LIMIT.
- Clears on host grant or on host_req=0.
- Not used in LOCKED.

Pipeline (accept in cycle N):
- N+1: mem_en=1; mem_we, mem_addr, mem_wdata = the winner's values; owner tag and read flag registered.
- N+2: mem_rdata valid; captured into the owner's rdata register.
- N+3: owner's rvalid=1 for exactly one cycle, rdata stable.
- Writes produce no rvalid.
- Cycles with no accepted access drive mem_en=0.
- Back-to-back accepts on consecutive cycles are allowed, mixing owners. Return order equals accept order, so per-requester read-after-write order is preserved by the RAM.

Other rules:
- rdata holds its last value when rvalid=0.
- Requests with req=0 ignore all address/data inputs.
- host_lock is ignored unless the host access is accepted.
- Simultaneous core_req & host_req in ARB: core wins unless starve==STARVE_LIMIT.
- Simultaneous read return and new accept for the same owner: both proceed; no backpressure on return.

Test Plan:
1. RAM[0x0005]=0x2A; core read 0x0005 in cycle 0 -> core_gnt=1 at 0; mem_en=1, mem_we=0, mem_addr=0x0005 at 1; core_rvalid=1, core_rdata=0x2A at 3; host_rvalid stays 0.
2. STARVE_LIMIT=4; core_req and host_req held high continuously -> core granted cycles 0-3; host granted cycle 4; core granted cycles 5-8; host granted cycle 9.
3. Host write 0x0010<-0x7F with host_lock=1 -> locked=1 next cycle. Core_req held 10 cycles -> core_gnt=0 throughout. Host read 0x0010 with host_lock=0 -> host_rdata=0x7F; locked=0 and core_gnt=1 the following cycle.
4. Core read accepted at cycle 0; reset_n pulled low at cycle 1 -> mem_en=0 immediately; no core_rvalid in cycles 1-6 after reset_n rises.
5. Core write 0x0003<-0x11 at cycle 0, core read 0x0003 at cycle 1 -> core_rvalid at 4 with core_rdata=0x11; mem_* show write at 1 and read at 2.
6. Host alone issues reads on 4 consecutive cycles to 0x0000-0x0003 (RAM=0xA0..0xA3) -> host_rvalid high cycles 3-6 with rdata 0xA0, 0xA1, 0xA2, 0xA3 in order.
